// File: rtl/hazard_ctrl_stage_if.sv
// Pipeline hazard-control bundle between the ID/EX pipeline and the
// hazard controller. The master side supplies the ID/EX observations;
// the slave side is the hazard controller itself.
interface hazard_ctrl_stage_if #(
  parameter int CTRL_W = 13,
  parameter int REG_AW = 5
);
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              branch_taken;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_valid;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic [15:0]       bubble_cnt;

  modport master (
    output id_ctrl, id_valid, id_rs1, id_rs2, id_uses_rs2,
           ex_rd, ex_mem_read, branch_taken,
    input  ex_ctrl, ex_valid, pc_write, if_id_write, if_id_flush, bubble_cnt
  );

  modport slave (
    input  id_ctrl, id_valid, id_rs1, id_rs2, id_uses_rs2,
           ex_rd, ex_mem_read, branch_taken,
    output ex_ctrl, ex_valid, pc_write, if_id_write, if_id_flush, bubble_cnt
  );
endinterface

// File: rtl/hazard_ctrl_stage.sv
// Load-use stall and branch flush controller for the ID->EX boundary.
// Taken branches open a FLUSH window, load-use hazards open a STALL window;
// either window injects bubbles into EX and bubble_cnt counts them.
module hazard_ctrl_stage #(
  parameter int CTRL_W       = 13,
  parameter int REG_AW       = 5,
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  hazard_ctrl_stage_if.slave bus
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  // Window counters hold "remaining cycles after the next one", hence the -2.
  localparam logic [3:0] STALL_LOAD = 4'((STALL_CYCLES > 1) ? STALL_CYCLES - 2 : 0);
  localparam logic [3:0] FLUSH_LOAD = 4'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  state_t            state;
  logic [3:0]        cnt;
  logic              hazard;
  logic              flushing;
  logic              stalling;
  logic              bubble;
  logic [CTRL_W-1:0] next_ctrl;

  // Hazard detection and per-cycle pipeline control decisions.
  always_comb begin
    // Reset gating keeps PC/IF-ID enabled while the pipeline is held in reset.
    hazard = rst_n & bus.id_valid & bus.ex_mem_read & (bus.ex_rd != REG_AW'(0)) &
             ((bus.ex_rd == bus.id_rs1) | (bus.id_uses_rs2 & (bus.ex_rd == bus.id_rs2)));
    flushing         = bus.branch_taken | (state == FLUSH);
    stalling         = ~flushing & (((state == RUN) & hazard) | (state == STALL));
    bubble           = flushing | stalling;
    next_ctrl        = bubble ? '0 : bus.id_ctrl;
    bus.pc_write     = ~stalling;
    bus.if_id_write  = ~stalling;
    bus.if_id_flush  = flushing;
  end

  // Window FSM, ID->EX control register and saturating bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      cnt            <= '0;
      bus.ex_ctrl    <= '0;
      bus.ex_valid   <= 1'b0;
      bus.bubble_cnt <= '0;
    end else begin
      bus.ex_ctrl  <= next_ctrl;
      bus.ex_valid <= bubble ? 1'b0 : bus.id_valid;
      if (bubble && (bus.bubble_cnt != '1))
        bus.bubble_cnt <= bus.bubble_cnt + 16'd1;

      if (bus.branch_taken) begin
        // A taken branch pre-empts any open stall window.
        state <= (FLUSH_CYCLES == 1) ? RUN : FLUSH;
        cnt   <= FLUSH_LOAD;
      end else begin
        case (state)
          RUN: begin
            if (hazard && (STALL_CYCLES > 1)) begin
              state <= STALL;
              cnt   <= STALL_LOAD;
            end
          end
          STALL, FLUSH: begin
            if (cnt == '0) state <= RUN;
            else           cnt   <= cnt - 4'd1;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_stage.sv
// Bench for hazard_ctrl_stage: two instances (stall/flush windows 1/1 and
// 3/2) share one stimulus stream and are checked every cycle against a
// remaining-cycles model, plus directed literal expectations.
module tb_hazard_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] id_ctrl;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs2, ex_mem_read, branch_taken;
  bit          started = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_stage_if #(.CTRL_W(13), .REG_AW(5)) ifa ();
  hazard_ctrl_stage_if #(.CTRL_W(13), .REG_AW(5)) ifb ();

  assign ifa.id_ctrl = id_ctrl;       assign ifb.id_ctrl = id_ctrl;
  assign ifa.id_valid = id_valid;     assign ifb.id_valid = id_valid;
  assign ifa.id_rs1 = id_rs1;         assign ifb.id_rs1 = id_rs1;
  assign ifa.id_rs2 = id_rs2;         assign ifb.id_rs2 = id_rs2;
  assign ifa.id_uses_rs2 = id_uses_rs2; assign ifb.id_uses_rs2 = id_uses_rs2;
  assign ifa.ex_rd = ex_rd;           assign ifb.ex_rd = ex_rd;
  assign ifa.ex_mem_read = ex_mem_read; assign ifb.ex_mem_read = ex_mem_read;
  assign ifa.branch_taken = branch_taken; assign ifb.branch_taken = branch_taken;

  hazard_ctrl_stage #(.CTRL_W(13), .REG_AW(5), .STALL_CYCLES(1), .FLUSH_CYCLES(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  hazard_ctrl_stage #(.CTRL_W(13), .REG_AW(5), .STALL_CYCLES(3), .FLUSH_CYCLES(2))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  logic [12:0] d_ctrl [2];
  logic        d_valid[2], d_pcw[2], d_ifw[2], d_flush[2];
  logic [15:0] d_bub  [2];
  assign d_ctrl[0] = ifa.ex_ctrl;   assign d_ctrl[1] = ifb.ex_ctrl;
  assign d_valid[0] = ifa.ex_valid; assign d_valid[1] = ifb.ex_valid;
  assign d_pcw[0] = ifa.pc_write;   assign d_pcw[1] = ifb.pc_write;
  assign d_ifw[0] = ifa.if_id_write; assign d_ifw[1] = ifb.if_id_write;
  assign d_flush[0] = ifa.if_id_flush; assign d_flush[1] = ifb.if_id_flush;
  assign d_bub[0] = ifa.bubble_cnt; assign d_bub[1] = ifb.bubble_cnt;

  // ---------------- reference model ----------------
  int unsigned stall_left[2], flush_left[2], m_bub[2];
  logic [12:0] m_ctrl[2];
  logic        m_valid[2];

  function automatic int unsigned s_len(int k); return (k == 0) ? 1 : 3; endfunction
  function automatic int unsigned f_len(int k); return (k == 0) ? 1 : 2; endfunction

  function automatic bit m_hazard();
    return rst_n && id_valid && ex_mem_read && (ex_rd != 0) &&
           ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  endfunction
  function automatic bit m_flush(int k);
    return branch_taken || (flush_left[k] != 0);
  endfunction
  function automatic bit m_stall(int k);
    return !m_flush(k) && ((stall_left[k] != 0) || m_hazard());
  endfunction

  // Model advances on the same edges as the DUTs.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        stall_left[k] = 0; flush_left[k] = 0; m_bub[k] = 0;
        m_ctrl[k] = '0;    m_valid[k] = 1'b0;
      end else begin
        bit bub;
        bit hz;
        bub = m_flush(k) || m_stall(k);
        hz  = m_hazard();
        m_ctrl[k]  = bub ? 13'h0 : id_ctrl;
        m_valid[k] = bub ? 1'b0 : id_valid;
        if (bub && m_bub[k] < 65535) m_bub[k] = m_bub[k] + 1;
        if (branch_taken) begin
          flush_left[k] = f_len(k) - 1; stall_left[k] = 0;
        end else if (flush_left[k] != 0) flush_left[k] = flush_left[k] - 1;
        else if (stall_left[k] != 0)     stall_left[k] = stall_left[k] - 1;
        else if (hz)                     stall_left[k] = s_len(k) - 1;
      end
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        check("ex_ctrl", k, 32'(d_ctrl[k]), 32'(m_ctrl[k]));
        check("ex_valid", k, 32'(d_valid[k]), 32'(m_valid[k]));
        check("bubble_cnt", k, 32'(d_bub[k]), m_bub[k]);
        check("pc_write", k, 32'(d_pcw[k]), 32'(!m_stall(k)));
        check("if_id_write", k, 32'(d_ifw[k]), 32'(!m_stall(k)));
        check("if_id_flush", k, 32'(d_flush[k]), 32'(m_flush(k)));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_ctrl = '0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0;
    ex_rd = '0; ex_mem_read = 1'b0; branch_taken = 1'b0;
  endtask

  // Runs n cycles from the currently-driven inputs, dropping the load after
  // the first cycle, optionally pulsing branch_taken at cycle br_at, and
  // counts held-PC and flush cycles per instance.
  task automatic window(input int n, input int br_at,
                        output int st0, output int st1, output int fl0, output int fl1);
    st0 = 0; st1 = 0; fl0 = 0; fl1 = 0;
    for (int i = 0; i < n; i++) begin
      if (i == br_at) branch_taken = 1'b1;
      #1;
      if (!d_pcw[0]) st0++;
      if (!d_pcw[1]) st1++;
      if (d_flush[0]) fl0++;
      if (d_flush[1]) fl1++;
      cyc();
      ex_mem_read  = 1'b0;
      branch_taken = 1'b0;
    end
  endtask

  initial begin
    int st0, st1, fl0, fl1;
    logic [15:0] b0, b1;
    idle();
    rst_n   = 1'b0;
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("lit_rst_ex_ctrl", 1, 32'(ifb.ex_ctrl), 32'h0);
    check("lit_rst_pc_write", 1, 32'(ifb.pc_write), 32'h1);
    rst_n = 1'b1;

    // Plain pass-through.
    id_ctrl = 13'h0A5; id_valid = 1'b1;
    cyc();
    check("lit_pass_ctrl_a", 0, 32'(ifa.ex_ctrl), 32'h0A5);
    check("lit_pass_valid_b", 1, 32'(ifb.ex_valid), 32'h1);
    check("lit_pass_bub_b", 1, 32'(ifb.bubble_cnt), 32'h0);

    // Load-use on rs1.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    window(6, -1, st0, st1, fl0, fl1);
    check("lit_rs1_stalls_a", 0, st0, 1);
    check("lit_rs1_stalls_b", 1, st1, 3);
    check("lit_rs1_bub_a", 0, 32'(ifa.bubble_cnt), 1);
    check("lit_rs1_bub_b", 1, 32'(ifb.bubble_cnt), 3);

    // Load-use on rs2.
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd3; id_uses_rs2 = 1'b1;
    window(6, -1, st0, st1, fl0, fl1);
    check("lit_rs2_stalls_b", 1, st1, 3);
    check("lit_rs2_bub_b", 1, 32'(ifb.bubble_cnt), 6);

    // x0 destination never stalls.
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs2 = 1'b0; id_ctrl = 13'h1234;
    #1;
    check("lit_x0_pc_write_b", 1, 32'(ifb.pc_write), 1);
    cyc();
    check("lit_x0_ctrl_b", 1, 32'(ifb.ex_ctrl), 32'h1234);
    ex_mem_read = 1'b0;

    // Branch during the second cycle of a stall window.
    b0 = ifa.bubble_cnt; b1 = ifb.bubble_cnt;
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    window(6, 1, st0, st1, fl0, fl1);
    check("lit_br_flush_b", 1, fl1, 2);
    check("lit_br_stalls_b", 1, st1, 1);
    check("lit_br_flush_a", 0, fl0, 1);
    check("lit_br_bub_b", 1, 32'(ifb.bubble_cnt - b1), 3);
    check("lit_br_bub_a", 0, 32'(ifa.bubble_cnt - b0), 2);

    // Randomized traffic with occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      id_ctrl      = 13'($urandom);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_uses_rs2  = 1'($urandom);
      ex_rd        = 5'($urandom_range(0, 3));
      ex_mem_read  = 1'($urandom);
      branch_taken = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    // Saturation of the bubble counter under a continuous hazard.
    idle();
    rst_n = 1'b0;
    cyc();
    id_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    rst_n = 1'b1;
    repeat (65534) cyc();
    check("lit_sat_fffe_a", 0, 32'(ifa.bubble_cnt), 32'hFFFE);
    check("lit_sat_fffe_b", 1, 32'(ifb.bubble_cnt), 32'hFFFE);
    repeat (3) cyc();
    check("lit_sat_ffff_a", 0, 32'(ifa.bubble_cnt), 32'hFFFF);
    check("lit_sat_ffff_b", 1, 32'(ifb.bubble_cnt), 32'hFFFF);
    rst_n = 1'b0;
    #1;
    check("lit_rst2_bub_b", 1, 32'(ifb.bubble_cnt), 0);
    check("lit_rst2_valid_b", 1, 32'(ifb.ex_valid), 0);
    check("lit_rst2_pc_write_b", 1, 32'(ifb.pc_write), 1);
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
